// File: rtl/ue1_host.sv
// Memory-side sequencer for a UE-1 1-bit core. It fetches program words, feeds the core
// and applies the core's flag outputs. Define UE1_HOST_SINGLESTEP_EN to add the step input.
module ue1_host #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef UE1_HOST_SINGLESTEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic            cpu_clk_en,
  output logic [3:0]      cpu_instr,
  output logic            cpu_data,
  input  logic            cpu_rr,
  input  logic            cpu_write,
  input  logic            cpu_jmp,
  input  logic            cpu_rtn,
  input  logic            cpu_skip,
  input  logic            cpu_nopf,
  input  logic [7:0]      ext_in,
  output logic [7:0]      ext_out,
  output logic            halted,
  output logic            stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_TGT_FETCH,
    S_TGT_LOAD
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ram_q, ram_d;
  logic [7:0]        ext_out_q, ext_out_d;
  logic              halted_q, halted_d;
  logic              stack_err_q, stack_err_d;
  logic              skip_pend_q, skip_pend_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];
  logic [PC_W-1:0]   stack_d [STACK_DEPTH];

  logic              advance;
  logic [3:0]        io_addr;
  logic              io_bit;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_inc2;
  logic [IDX_W-1:0]  top_idx;
  logic              stack_full;
  logic              stack_empty;

`ifdef UE1_HOST_SINGLESTEP_EN
  logic step_q, step_d;
  logic step_pend_q, step_pend_d;

  assign advance = run | step_pend_q;

  always_comb begin
    step_d      = step;
    step_pend_d = step_pend_q;
    if (state_q == S_FETCH && advance && !halted_q) step_pend_d = 1'b0;
    if (step && !step_q && !run)                    step_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign advance = run;
`endif

  assign io_addr     = prog_data[3:0];
  assign io_bit      = io_addr[3] ? ext_in[io_addr[2:0]] : ram_q[io_addr[2:0]];
  assign pc_inc      = pc_q + PC_W'(1);
  assign pc_inc2     = pc_q + PC_W'(2);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // NOTE: every output and next-state value gets a default before the case, so no path
  // through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ram_d       = ram_q;
    ext_out_d   = ext_out_q;
    halted_d    = halted_q;
    stack_err_d = stack_err_q;
    skip_pend_d = skip_pend_q;
    sp_d        = sp_q;
    stack_d     = stack_q;
    prog_addr   = pc_q;
    cpu_clk_en  = 1'b0;
    cpu_instr   = 4'h0;
    cpu_data    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (advance && !halted_q) state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (skip_pend_q) begin
          // The skipped word was fetched but the core never sees a clock for it.
          skip_pend_d = 1'b0;
          pc_d        = pc_inc;
        end else begin
          cpu_clk_en = 1'b1;
          cpu_instr  = prog_data[7:4];
          cpu_data   = io_bit;

          if (cpu_write) begin
            if (io_addr[3]) ext_out_d[io_addr[2:0]] = cpu_rr;
            else            ram_d[io_addr[2:0]]     = cpu_rr;
          end

          if (cpu_nopf && io_addr == 4'hF) halted_d = 1'b1;

          if (cpu_jmp) begin
            state_d = S_TGT_FETCH;
          end else if (cpu_rtn) begin
            if (stack_empty) begin
              pc_d        = '0;
              stack_err_d = 1'b1;
            end else begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - SP_W'(1);
            end
          end else begin
            pc_d = pc_inc;
            if (cpu_skip) skip_pend_d = 1'b1;
          end
        end
      end

      S_TGT_FETCH: begin
        prog_addr = pc_inc;
        state_d   = S_TGT_LOAD;
      end

      S_TGT_LOAD: begin
        prog_addr = pc_inc;
        pc_d      = prog_data[PC_W-1:0];
        state_d   = S_FETCH;
        // Overflow keeps the most recent return address by overwriting the top entry.
        if (stack_full) begin
          stack_err_d      = 1'b1;
          stack_d[top_idx] = pc_inc2;
        end else begin
          stack_d[sp_q[IDX_W-1:0]] = pc_inc2;
          sp_d                     = sp_q + SP_W'(1);
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: the bit RAM and return stack are small flop arrays, so they take the async
  // reset like the rest of the state; a macro RAM could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ram_q       <= '0;
      ext_out_q   <= '0;
      halted_q    <= 1'b0;
      stack_err_q <= 1'b0;
      skip_pend_q <= 1'b0;
      sp_q        <= '0;
      stack_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ram_q       <= ram_d;
      ext_out_q   <= ext_out_d;
      halted_q    <= halted_d;
      stack_err_q <= stack_err_d;
      skip_pend_q <= skip_pend_d;
      sp_q        <= sp_d;
      stack_q     <= stack_d;
    end
  end

  assign ext_out   = ext_out_q;
  assign halted    = halted_q;
  assign stack_err = stack_err_q;

endmodule

// File: tb/tb_ue1_host.sv
// Directed bench for ue1_host: a registered ROM model plus a stand-in core that raises
// WRITE/JMP/RTN/SKIP/NOPF from the opcode it is clocked with.
module tb_ue1_host;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       cpu_clk_en;
  logic [3:0] cpu_instr;
  logic       cpu_data;
  logic       cpu_rr;
  logic       cpu_write;
  logic       cpu_jmp;
  logic       cpu_rtn;
  logic       cpu_skip;
  logic       cpu_nopf;
  logic [7:0] ext_in;
  logic [7:0] ext_out;
  logic       halted;
  logic       stack_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom [256];

  ue1_host #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .cpu_clk_en (cpu_clk_en),
    .cpu_instr  (cpu_instr),
    .cpu_data   (cpu_data),
    .cpu_rr     (cpu_rr),
    .cpu_write  (cpu_write),
    .cpu_jmp    (cpu_jmp),
    .cpu_rtn    (cpu_rtn),
    .cpu_skip   (cpu_skip),
    .cpu_nopf   (cpu_nopf),
    .ext_in     (ext_in),
    .ext_out    (ext_out),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  // Stand-in core: STO=8, JMP=C, RTN=D, SKZ=E (unconditional here), NOPF=F.
  always_comb begin
    cpu_write = cpu_clk_en && cpu_instr == 4'h8;
    cpu_jmp   = cpu_clk_en && cpu_instr == 4'hC;
    cpu_rtn   = cpu_clk_en && cpu_instr == 4'hD;
    cpu_skip  = cpu_clk_en && cpu_instr == 4'hE;
    cpu_nopf  = cpu_clk_en && cpu_instr == 4'hF;
  end

  typedef struct {
    logic [7:0] addr;
    logic       en;
    logic [3:0] instr;
    logic       data;
    logic [7:0] eout;
    logic       halt;
    logic       err;
  } vec_t;

  vec_t vecs [36];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic [7:0] a, input logic e, input logic [3:0] ins,
                         input logic d, input logic [7:0] eo, input logic h);
    vecs[i] = '{a, e, ins, d, eo, h, 1'b0};
  endtask

  initial begin
    rst_n  = 1'b0;
    run    = 1'b0;
    cpu_rr = 1'b1;
    ext_in = 8'h02;

    // Program A: sequential fetch, ext write, JMP/RTN, SKIP, halt.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h20; rom[8'h02] = 8'h30;
    rom[8'h03] = 8'h89; rom[8'h04] = 8'h19; rom[8'h05] = 8'hC0;
    rom[8'h06] = 8'h40; rom[8'h0A] = 8'hE0; rom[8'h0B] = 8'h50;
    rom[8'h0C] = 8'h60; rom[8'h0D] = 8'hFF;
    rom[8'h40] = 8'h83; rom[8'h41] = 8'h13; rom[8'h42] = 8'hD0;

    set_vec( 0, 8'h00, 1, 4'h1, 0, 8'h00, 0);
    set_vec( 1, 8'h01, 0, 4'h0, 0, 8'h00, 0);
    set_vec( 2, 8'h01, 1, 4'h2, 0, 8'h00, 0);
    set_vec( 3, 8'h02, 0, 4'h0, 0, 8'h00, 0);
    set_vec( 4, 8'h02, 1, 4'h3, 0, 8'h00, 0);
    set_vec( 5, 8'h03, 0, 4'h0, 0, 8'h00, 0);
    set_vec( 6, 8'h03, 1, 4'h8, 1, 8'h00, 0);
    set_vec( 7, 8'h04, 0, 4'h0, 0, 8'h02, 0);
    set_vec( 8, 8'h04, 1, 4'h1, 1, 8'h02, 0);
    set_vec( 9, 8'h05, 0, 4'h0, 0, 8'h02, 0);
    set_vec(10, 8'h05, 1, 4'hC, 0, 8'h02, 0);
    set_vec(11, 8'h06, 0, 4'h0, 0, 8'h02, 0);
    set_vec(12, 8'h06, 0, 4'h0, 0, 8'h02, 0);
    set_vec(13, 8'h40, 0, 4'h0, 0, 8'h02, 0);
    set_vec(14, 8'h40, 1, 4'h8, 0, 8'h02, 0);
    set_vec(15, 8'h41, 0, 4'h0, 0, 8'h02, 0);
    set_vec(16, 8'h41, 1, 4'h1, 1, 8'h02, 0);
    set_vec(17, 8'h42, 0, 4'h0, 0, 8'h02, 0);
    set_vec(18, 8'h42, 1, 4'hD, 0, 8'h02, 0);
    set_vec(19, 8'h07, 0, 4'h0, 0, 8'h02, 0);
    set_vec(20, 8'h07, 1, 4'h0, 0, 8'h02, 0);
    set_vec(21, 8'h08, 0, 4'h0, 0, 8'h02, 0);
    set_vec(22, 8'h08, 1, 4'h0, 0, 8'h02, 0);
    set_vec(23, 8'h09, 0, 4'h0, 0, 8'h02, 0);
    set_vec(24, 8'h09, 1, 4'h0, 0, 8'h02, 0);
    set_vec(25, 8'h0A, 0, 4'h0, 0, 8'h02, 0);
    set_vec(26, 8'h0A, 1, 4'hE, 0, 8'h02, 0);
    set_vec(27, 8'h0B, 0, 4'h0, 0, 8'h02, 0);
    set_vec(28, 8'h0B, 0, 4'h0, 0, 8'h02, 0);
    set_vec(29, 8'h0C, 0, 4'h0, 0, 8'h02, 0);
    set_vec(30, 8'h0C, 1, 4'h6, 0, 8'h02, 0);
    set_vec(31, 8'h0D, 0, 4'h0, 0, 8'h02, 0);
    set_vec(32, 8'h0D, 1, 4'hF, 0, 8'h02, 0);
    set_vec(33, 8'h0E, 0, 4'h0, 0, 8'h02, 1);
    set_vec(34, 8'h0E, 0, 4'h0, 0, 8'h02, 1);
    set_vec(35, 8'h0E, 0, 4'h0, 0, 8'h02, 1);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("hold_run0_%0d", i), {prog_addr, 7'd0, cpu_clk_en}, {8'h00, 7'd0, 1'b0});
    end
    run = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      check($sformatf("progA_cyc%0d", i + 1),
            {prog_addr, cpu_clk_en, cpu_instr, cpu_data, ext_out, halted, stack_err},
            {vecs[i].addr, vecs[i].en, vecs[i].instr, vecs[i].data, vecs[i].eout,
             vecs[i].halt, vecs[i].err});
    end

    // RTN with an empty stack.
    clear_rom();
    rom[8'h00] = 8'hD0;
    do_reset();
    check("rst_ext_out", ext_out, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_stack_err", stack_err, 1'b0);
    run = 1'b1;
    @(negedge clk);
    check("rtn_empty_exec", {cpu_clk_en, cpu_instr}, {1'b1, 4'hD});
    @(negedge clk);
    check("rtn_empty_pc", prog_addr, 8'h00);
    check("rtn_empty_err", stack_err, 1'b1);

    // Five nested JMPs overflow a four-deep stack; then reset lands inside TGT_LOAD.
    clear_rom();
    rom[8'h00] = 8'hC0; rom[8'h01] = 8'h10;
    rom[8'h10] = 8'hC0; rom[8'h11] = 8'h20;
    rom[8'h20] = 8'hC0; rom[8'h21] = 8'h30;
    rom[8'h30] = 8'hC0; rom[8'h31] = 8'h40;
    rom[8'h40] = 8'hC0; rom[8'h41] = 8'h50;
    rom[8'h50] = 8'hC0; rom[8'h51] = 8'h60;
    do_reset();
    run = 1'b1;
    repeat (16) @(negedge clk);
    check("jmp4_pc", prog_addr, 8'h40);
    check("jmp4_no_err", stack_err, 1'b0);
    repeat (4) @(negedge clk);
    check("jmp5_pc", prog_addr, 8'h50);
    check("jmp5_overflow", stack_err, 1'b1);
    repeat (3) @(negedge clk);
    check("tgt_load_addr", prog_addr, 8'h51);
    rst_n = 1'b0;
    #1;
    check("midjmp_rst_outs",
          {prog_addr, cpu_clk_en, cpu_instr, cpu_data, ext_out, halted, stack_err},
          {8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    check("midjmp_rst_hold", {prog_addr, cpu_clk_en}, {8'h00, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_exec", {prog_addr, cpu_clk_en, cpu_instr}, {8'h00, 1'b1, 4'hC});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
